// File: rtl/clic_seq_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// clic_seq_arbiter_pkg
// Shared sizing and types for the sequential CLIC arbiter.
//   NR_PRIO_BITS  : priority width; priority 0 is never offered
//   NR_INDEX_BITS : vector index width, NR_VECTORS = 2**NR_INDEX_BITS
//   LANES         : table entries compared per scan cycle (power of two,
//                   divides NR_VECTORS); NR_GROUPS scan cycles per pass
// Types: Entry (one priority), Index (vector number), Entries (whole table),
//        Pend (per-vector bit vector), LaneEntries (one scan group),
//        ArbState (arbiter FSM states).
// -----------------------------------------------------------------------------
package clic_seq_arbiter_pkg;

   localparam int unsigned NR_PRIO_BITS  = 3;
   localparam int unsigned NR_INDEX_BITS = 2;
   localparam int unsigned NR_VECTORS    = 2 ** NR_INDEX_BITS;
   localparam int unsigned LANES         = 2;
   localparam int unsigned NR_GROUPS     = NR_VECTORS / LANES;

   typedef logic [NR_PRIO_BITS-1:0]  Entry;
   typedef logic [NR_INDEX_BITS-1:0] Index;
   typedef Entry [NR_VECTORS-1:0]    Entries;
   typedef logic [NR_VECTORS-1:0]    Pend;
   typedef Entry [LANES-1:0]         LaneEntries;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      OFFER
   } ArbState;

   // Base index of the final scan group; reaching it ends a pass.
   localparam Index LAST_BASE = Index'(NR_VECTORS - LANES);

endpackage

// File: rtl/clic_group_max.sv
// -----------------------------------------------------------------------------
// clic_group_max
// Combinational maximum over one scan group of LANES priorities.
// Ports:
//   cand      in  : LANES candidate priorities (already zeroed when the
//                   vector is not pending and enabled)
//   base      in  : vector index of cand[0]
//   max_prio  out : largest candidate priority (0 if none)
//   max_index out : vector index of that candidate; lowest index on ties
// -----------------------------------------------------------------------------
module clic_group_max
   import clic_seq_arbiter_pkg::*;
(
   input  LaneEntries cand,
   input  Index       base,
   output Entry       max_prio,
   output Index       max_index
);

   always_comb begin
      // NOTE: every output gets a default before the loop, so no path leaves
      // it unassigned and no latch is inferred.
      max_prio  = '0;
      max_index = base;
      // Strict compare: an equal priority at a higher lane never displaces
      // the earlier one, giving the lower index the win.
      for (int i = 0; i < int'(LANES); i++) begin
         if (cand[i] > max_prio) begin
            max_prio  = cand[i];
            max_index = base + Index'(i);
         end
      end
   end

endmodule

// File: rtl/clic_seq_arbiter.sv
// -----------------------------------------------------------------------------
// clic_seq_arbiter
// Priority table + pending/enable bits; finds the highest-priority pending and
// enabled vector with a LANES-wide sequential scan (NR_GROUPS cycles) and
// offers it over a valid/ready claim handshake gated by a threshold.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   prio_we/waddr/wdata    : priority table write port
//   pend_set               : per-vector pending set pulses
//   enable                 : per-vector enable level
//   threshold              : running priority; offers need prio > threshold
//   irq_valid/index/prio   : offer to the core, stable until claimed
//   irq_ready              : core claims the offer (clears its pending bit)
// Build option: define CLIC_WITHDRAW_EN to withdraw an offer whose vector is
// disabled or whose priority no longer beats the threshold.
// -----------------------------------------------------------------------------
module clic_seq_arbiter
   import clic_seq_arbiter_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     prio_we,
   input  logic [NR_INDEX_BITS-1:0] prio_waddr,
   input  logic [NR_PRIO_BITS-1:0]  prio_wdata,
   input  logic [NR_VECTORS-1:0]    pend_set,
   input  logic [NR_VECTORS-1:0]    enable,
   input  logic [NR_PRIO_BITS-1:0]  threshold,
   output logic                     irq_valid,
   output logic [NR_INDEX_BITS-1:0] irq_index,
   output logic [NR_PRIO_BITS-1:0]  irq_prio,
   input  logic                     irq_ready
);

   ArbState    state_q, state_d;
   Entries     prio_tab_q;
   Pend        pending_q;
   Pend        qual;
   Pend        claim_clr;
   Index       base_q, base_d;
   Entry       best_prio_q, best_prio_d;
   Index       best_idx_q, best_idx_d;
   LaneEntries cand;
   Entry       grp_prio;
   Index       grp_idx;
   Entry       scan_prio;
   Index       scan_idx;
   logic       load_offer;

   assign qual = pending_q & enable;

   // Current scan group; unqualified vectors compete as priority 0.
   always_comb begin
      for (int i = 0; i < int'(LANES); i++) begin
         cand[i] = qual[base_q + Index'(i)] ? prio_tab_q[base_q + Index'(i)] : '0;
      end
   end

   clic_group_max u_group_max (
      .cand      (cand),
      .base      (base_q),
      .max_prio  (grp_prio),
      .max_index (grp_idx)
   );

   // Running best including this group; earlier groups win ties.
   assign scan_prio = (grp_prio > best_prio_q) ? grp_prio : best_prio_q;
   assign scan_idx  = (grp_prio > best_prio_q) ? grp_idx  : best_idx_q;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      best_prio_d = best_prio_q;
      best_idx_d  = best_idx_q;
      load_offer  = 1'b0;
      claim_clr   = '0;
      irq_valid   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (|qual) begin
               best_prio_d = '0;
               best_idx_d  = '0;
               base_d      = '0;
               state_d     = SCAN;
            end
         end
         SCAN: begin
            best_prio_d = scan_prio;
            best_idx_d  = scan_idx;
            base_d      = base_q + Index'(LANES);
            if (base_q == LAST_BASE) begin
               // threshold >= 0 makes this also reject priority 0.
               if (scan_prio > threshold) begin
                  load_offer = 1'b1;
                  state_d    = OFFER;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         OFFER: begin
            irq_valid = 1'b1;
            if (irq_ready) begin
               claim_clr[irq_index] = 1'b1;
               state_d              = IDLE;
            end
`ifdef CLIC_WITHDRAW_EN
            // Withdraw leaves pending untouched so the vector is rescanned
            // once it qualifies again; a simultaneous claim takes precedence.
            else if (!enable[irq_index] || (threshold >= irq_prio)) begin
               state_d = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the priority table is reset with the rest of the state; it is
         // small and software expects every vector to start at priority 0.
         state_q     <= IDLE;
         prio_tab_q  <= '0;
         pending_q   <= '0;
         base_q      <= '0;
         best_prio_q <= '0;
         best_idx_q  <= '0;
         irq_index   <= '0;
         irq_prio    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q     <= state_d;
         base_q      <= base_d;
         best_prio_q <= best_prio_d;
         best_idx_q  <= best_idx_d;
         if (load_offer) begin
            irq_index <= scan_idx;
            irq_prio  <= scan_prio;
         end
         if (prio_we) begin
            prio_tab_q[prio_waddr] <= prio_wdata;
         end
         // A set pulse on the claimed vector re-arms it in the same edge.
         pending_q <= (pending_q & ~claim_clr) | pend_set;
      end
   end

endmodule

// File: tb/tb_clic_seq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_clic_seq_arbiter
// Directed stimulus for clic_seq_arbiter with a cycle-level reference model
// (flat argmax over the whole table at the end of each scan pass) compared on
// every falling edge, plus hand-computed expectations for each scenario.
// Honours CLIC_WITHDRAW_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_clic_seq_arbiter;
   import clic_seq_arbiter_pkg::*;

   localparam int G = int'(NR_GROUPS);

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     prio_we;
   logic [NR_INDEX_BITS-1:0] prio_waddr;
   logic [NR_PRIO_BITS-1:0]  prio_wdata;
   logic [NR_VECTORS-1:0]    pend_set;
   logic [NR_VECTORS-1:0]    enable;
   logic [NR_PRIO_BITS-1:0]  threshold;
   logic                     irq_valid;
   logic [NR_INDEX_BITS-1:0] irq_index;
   logic [NR_PRIO_BITS-1:0]  irq_prio;
   logic                     irq_ready;

   int checks   = 0;
   int failures = 0;

   clic_seq_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .prio_we    (prio_we),
      .prio_waddr (prio_waddr),
      .prio_wdata (prio_wdata),
      .pend_set   (pend_set),
      .enable     (enable),
      .threshold  (threshold),
      .irq_valid  (irq_valid),
      .irq_index  (irq_index),
      .irq_prio   (irq_prio),
      .irq_ready  (irq_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_scan: 0 = idle, k = k-th scan cycle of a pass.
   int m_tab [NR_VECTORS];
   bit m_pend[NR_VECTORS];
   int m_scan;
   bit m_valid;
   int m_idx, m_prio;
   bit m_init = 1'b0;
   int m_bp, m_bi, m_claim, m_p;
   bit m_any;

   // Inputs change at posedge+1, so at the falling edge they already hold the
   // values the next rising edge will sample. Compare first, then advance.
   initial begin
      forever begin
         @(negedge clk);
         if (m_init) begin
            check("cmp_valid", int'(irq_valid), int'(m_valid));
            if (m_valid) begin
               check("cmp_index", int'(irq_index), m_idx);
               check("cmp_prio", int'(irq_prio), m_prio);
            end
         end
         if (!rst_n) begin
            for (int i = 0; i < int'(NR_VECTORS); i++) begin
               m_tab[i]  = 0;
               m_pend[i] = 1'b0;
            end
            m_scan  = 0;
            m_valid = 1'b0;
            m_idx   = 0;
            m_prio  = 0;
            m_init  = 1'b1;
         end else begin
            m_claim = -1;
            if (m_valid) begin
               if (irq_ready) begin
                  m_claim = m_idx;
                  m_valid = 1'b0;
               end
`ifdef CLIC_WITHDRAW_EN
               else if (!enable[m_idx] || int'(threshold) >= m_prio) begin
                  m_valid = 1'b0;
               end
`endif
            end else if (m_scan == 0) begin
               m_any = 1'b0;
               for (int i = 0; i < int'(NR_VECTORS); i++)
                  if (m_pend[i] && enable[i]) m_any = 1'b1;
               if (m_any) m_scan = 1;
            end else if (m_scan < G) begin
               m_scan++;
            end else begin
               m_bp = 0;
               m_bi = 0;
               for (int i = 0; i < int'(NR_VECTORS); i++) begin
                  m_p = (m_pend[i] && enable[i]) ? m_tab[i] : 0;
                  if (m_p > m_bp) begin
                     m_bp = m_p;
                     m_bi = i;
                  end
               end
               m_scan = 0;
               if (m_bp > int'(threshold)) begin
                  m_valid = 1'b1;
                  m_idx   = m_bi;
                  m_prio  = m_bp;
               end
            end
            for (int i = 0; i < int'(NR_VECTORS); i++)
               m_pend[i] = (m_pend[i] && (i != m_claim)) || pend_set[i];
            if (prio_we) m_tab[prio_waddr] = int'(prio_wdata);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_prio(input int idx, input int prio);
      prio_we    = 1'b1;
      prio_waddr = NR_INDEX_BITS'(idx);
      prio_wdata = NR_PRIO_BITS'(prio);
      tick();
      prio_we = 1'b0;
   endtask

   // Waits for irq_valid; n is the number of cycles waited.
   task automatic wait_valid(input string name, input int budget, output int n);
      n = 0;
      while (!irq_valid && n < budget) begin
         tick();
         n++;
      end
      if (!irq_valid) check({name, "_timeout"}, 0, 1);
   endtask

   task automatic claim_offer(input string name, input int idx, input int prio);
      check({name, "_valid"}, int'(irq_valid), 1);
      check({name, "_index"}, int'(irq_index), idx);
      check({name, "_prio"}, int'(irq_prio), prio);
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      check({name, "_drop"}, int'(irq_valid), 0);
   endtask

   task automatic wait_offer(input string name, input int idx, input int prio,
                             input int gap);
      int n;
      wait_valid(name, 12, n);
      if (gap >= 0) check({name, "_gap"}, n, gap);
      claim_offer(name, idx, prio);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int tab2[4] = '{1, 3, 2, 3};
      int n;

      // 1. reset with pending pulses held active
      rst_n      = 1'b0;
      prio_we    = 1'b0;
      prio_waddr = '0;
      prio_wdata = '0;
      pend_set   = 4'hF;
      enable     = 4'hF;
      threshold  = '0;
      irq_ready  = 1'b0;
      tick();
      tick();
      check("rst_valid", int'(irq_valid), 0);
      check("rst_index", int'(irq_index), 0);
      check("rst_prio", int'(irq_prio), 0);
      rst_n    = 1'b1;
      pend_set = '0;
      repeat (8) begin
         tick();
         check("rst_nothing_pending", int'(irq_valid), 0);
      end

      // 2. ordering by priority, lower index on ties
      for (int i = 0; i < 4; i++) write_prio(i, tab2[i]);
      pend_set = 4'hF;
      tick();
      pend_set = '0;
      n = 1;
      while (!irq_valid && n < 20) begin
         tick();
         n++;
      end
      check("t2_latency", n, 4);
      claim_offer("t2_a", 1, 3);
      wait_offer("t2_b", 3, 3, 3);
      wait_offer("t2_c", 2, 2, 3);
      wait_offer("t2_d", 0, 1, 3);

      // 3. threshold gating
      threshold = 3'd3;
      pend_set  = 4'hF;
      tick();
      pend_set = '0;
      repeat (20) begin
         tick();
         check("t3_blocked", int'(irq_valid), 0);
      end
      threshold = 3'd2;
      wait_valid("t3_open", 10, n);
      check("t3_within_g2", int'(n <= 4), 1);
      claim_offer("t3_a", 1, 3);
      wait_offer("t3_b", 3, 3, 3);
      threshold = 3'd0;
      wait_offer("t3_c", 2, 2, -1);
      wait_offer("t3_d", 0, 1, 3);

      // 4. priority 0 is never offered
      write_prio(2, 0);
      pend_set = 4'b0100;
      tick();
      pend_set = '0;
      repeat (15) begin
         tick();
         check("t4_prio0", int'(irq_valid), 0);
      end

      // 5. set pulse coinciding with the claim keeps the vector pending
      write_prio(2, 2);
      wait_valid("t5_first", 10, n);
      check("t5_first_index", int'(irq_index), 2);
      irq_ready = 1'b1;
      pend_set  = 4'b0100;
      tick();
      irq_ready = 1'b0;
      pend_set  = '0;
      check("t5_drop", int'(irq_valid), 0);
      wait_offer("t5_reoffer", 2, 2, 3);
      repeat (10) begin
         tick();
         check("t5_empty", int'(irq_valid), 0);
      end

      // 6. enable cleared during an offer
      pend_set = 4'b0010;
      tick();
      pend_set = '0;
      wait_valid("t6_offer", 10, n);
      check("t6_index", int'(irq_index), 1);
      check("t6_prio", int'(irq_prio), 3);
      enable = 4'b1101;
      tick();
`ifdef CLIC_WITHDRAW_EN
      check("t6_withdrawn", int'(irq_valid), 0);
      repeat (5) begin
         tick();
         check("t6_stay_idle", int'(irq_valid), 0);
      end
      enable = 4'hF;
      wait_offer("t6_reoffer", 1, 3, -1);
`else
      check("t6_held", int'(irq_valid), 1);
      repeat (3) begin
         tick();
         check("t6_still_held", int'(irq_valid), 1);
         check("t6_held_index", int'(irq_index), 1);
      end
      claim_offer("t6_claim", 1, 3);
      enable = 4'hF;
`endif
      repeat (6) begin
         tick();
         check("t6_empty", int'(irq_valid), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clic_seq_arbiter.md
Name: clic_seq_arbiter

Overview:
Parametrised successor to the CLIC priority selection. Holds a per-vector priority table plus pending and enable bits. Finds the highest-priority pending and enabled vector with a multi-cycle, LANES-wide sequential scan, so area scales to large NR_INDEX_BITS. Offers the winner to the core over a valid/ready claim handshake gated by a priority threshold.

Parameters:
NR_PRIO_BITS, 3, priority width (package value); priority 0 = never taken
NR_INDEX_BITS, 2, vector index width; NR_VECTORS = 2**NR_INDEX_BITS
LANES, 2, entries compared per scan cycle; power of two, divides NR_VECTORS; G = NR_VECTORS/LANES scan cycles

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
prio_we  in  1  priority table write strobe
prio_waddr  in  NR_INDEX_BITS  table write index
prio_wdata  in  NR_PRIO_BITS  table write data
pend_set  in  NR_VECTORS  one-hot-or-multi pending set pulses
enable  in  NR_VECTORS  per-vector enable (level)
threshold  in  NR_PRIO_BITS  current running priority
irq_valid  out  1  offer valid
irq_index  out  NR_INDEX_BITS  offered vector
irq_prio  out  NR_PRIO_BITS  offered priority
irq_ready  in  1  core claims the offer

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset: priority table 0, pending 0, state IDLE, irq_valid 0, irq_index 0, irq_prio 0, scan registers 0.
- Pending: pending[i] <= (pending[i] & ~claim_clr[i]) | pend_set[i]. Simultaneous set and claim on the same index: set wins, so pending stays 1.
- Table write takes effect the next cycle. A write during SCAN may or may not be seen by the current scan; no error results.
- FSM IDLE: if |(pending & enable), clear best (prio 0, idx 0), base=0, go to SCAN. Otherwise stay.
- FSM SCAN: compare entries base..base+LANES-1 (pending & enable qualified; unqualified entries count as prio 0).
  - Update best only when candidate prio > best prio (strict), so the lower index wins ties.
  - base += LANES each cycle.
  - After group G-1: if best prio > threshold (unsigned, strict), go to OFFER. Otherwise go to IDLE and rescan on the next cycle.
- FSM OFFER: irq_valid=1; irq_index and irq_prio are registered and stable until the handshake.
  - On irq_valid & irq_ready: claim_clr[irq_index]=1; next state IDLE; irq_valid drops the next cycle.
  - Later writes to the offered vector's priority do not alter irq_prio.
- Latency: pend_set at cycle t gives irq_valid at t+G+2 (default 4). Back-to-back offers are separated by at least G+1 idle-valid cycles.
- Priority 0 is never offered, regardless of threshold.
- rst_n low in any state: all of the above resets in the same edge; an in-flight offer is dropped without a claim.

Optional Feature:
CLIC_WITHDRAW_EN
- Defined: in OFFER, if enable[irq_index]==0 or threshold >= irq_prio, drop irq_valid next cycle and go to IDLE with no claim_clr; pending is kept. Withdraw and irq_ready in the same cycle: the claim wins.
- Undefined: the offer is held until irq_ready, regardless of enable or threshold changes.

Decomposition:
- common_pkg gains:
  - NR_VECTORS
  - LANES default
  - typedef Entry, Index, Entries (existing)
  - typedef Pend (logic [NR_VECTORS-1:0])
  - enum ArbState {IDLE, SCAN, OFFER}
- Sub-module clic_group_max: combinational LANES-wide max with index output and lower-index tie-break; one instance per scan cycle path.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with pend_set=4'hF -> irq_valid=0, irq_index=0, irq_prio=0; pending remains 0 after release.
2. prio={0:1,1:3,2:2,3:3}, enable=4'hF, threshold=0, pend_set=4'hF at t -> irq_valid at t+4 with index 1, prio 3; ready -> next offer index 3, prio 3, then index 2, then index 0.
3. Same table, threshold=3 -> no offer for 20 cycles; set threshold=2 -> offer index 1, prio 3 within G+2 cycles.
4. Vector 2 with prio 0, pending, enabled, threshold 0 -> never offered; irq_valid stays 0.
5. Offer index 2 pending; pulse pend_set[2] in the same cycle as irq_ready -> pending[2] stays 1 and index 2 is re-offered.
6. With CLIC_WITHDRAW_EN defined: during an offer of index 1, clear enable[1] -> irq_valid=0 next cycle, pending[1]=1. Without the macro -> irq_valid stays 1 until ready.
